// File: rtl/pulse_cond_pkg.sv
// pulse_cond_pkg: shared types and defaults for the pulse conditioner.
// Holds the stretch FSM state encoding and default parameter values.
package pulse_cond_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_GAP
  } pc_state_t;

  localparam int DB_W_DEF    = 20;
  localparam int STRETCH_DEF = 4;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchroniser, async active-high reset to 0.
// Ports: clk_i, rst_i, d_i (async in), q_o (synchronised out).
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= d_i;
      r_s2 <= r_s1;
    end
  end

  assign q_o = r_s2;

endmodule

// File: rtl/pulse_conditioner.sv
// pulse_conditioner: sync + debounce + rising-edge detect + enable stretcher.
// Ports: clk_i, rst_i, btn_i, db_cycles_i -> level_o, pulse_o, en_o, busy_o, overrun_o.
module pulse_conditioner
  import pulse_cond_pkg::*;
#(
  parameter int DB_W    = DB_W_DEF,
  parameter int STRETCH = STRETCH_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            btn_i,
  input  logic [DB_W-1:0] db_cycles_i,
  output logic            level_o,
  output logic            pulse_o,
  output logic            en_o,
  output logic            busy_o,
  output logic            overrun_o
);

  localparam int SC_W = $clog2(STRETCH + 1);
  localparam logic [SC_W-1:0] SC_LOAD = SC_W'(STRETCH - 1);

  logic            w_sync;
  logic [DB_W-1:0] w_thr;
  logic [DB_W-1:0] r_cnt;
  logic            r_level;
  logic            r_level_q;
  logic            w_rise;
  logic            r_pulse;

  pc_state_t       r_state;
  pc_state_t       w_state_n;
  logic [SC_W-1:0] r_scnt;
  logic [SC_W-1:0] w_scnt_n;
  logic            r_pend;
  logic            w_pend_n;
  logic            r_en;
  logic            w_en_n;
  logic            r_busy;
  logic            w_busy_n;
  logic            r_ovr;
  logic            w_ovr_n;

  sync_2ff u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (btn_i),
    .q_o   (w_sync)
  );

  // A zero threshold would never match; treat it as one cycle.
  assign w_thr = (db_cycles_i == '0) ? DB_W'(1) : db_cycles_i;

  // >= keeps a lowered threshold from letting cnt run past it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (w_sync != r_level) begin
      if (r_cnt >= w_thr - 1'b1) begin
        r_level <= w_sync;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign w_rise = r_level & ~r_level_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_level_q <= 1'b0;
      r_pulse   <= 1'b0;
    end else begin
      r_level_q <= r_level;
      r_pulse   <= w_rise;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_scnt  <= '0;
      r_pend  <= 1'b0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_scnt  <= w_scnt_n;
      r_pend  <= w_pend_n;
      r_en    <= w_en_n;
      r_busy  <= w_busy_n;
      r_ovr   <= w_ovr_n;
    end
  end

  // In GAP the pending slot is still full, so a rise there with a press
  // already queued is the one that gets dropped.
  always_comb begin
    w_state_n = r_state;
    w_scnt_n  = r_scnt;
    w_pend_n  = r_pend;
    w_en_n    = 1'b0;
    w_ovr_n   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_n = ST_HIGH;
          w_scnt_n  = SC_LOAD;
          w_en_n    = 1'b1;
        end
      end
      ST_HIGH: begin
        if (w_rise) begin
          if (r_pend) w_ovr_n = 1'b1;
          else        w_pend_n = 1'b1;
        end
        if (r_scnt == '0) begin
          w_state_n = ST_GAP;
        end else begin
          w_scnt_n = r_scnt - 1'b1;
          w_en_n   = 1'b1;
        end
      end
      ST_GAP: begin
        if (r_pend || w_rise) begin
          w_state_n = ST_HIGH;
          w_scnt_n  = SC_LOAD;
          w_en_n    = 1'b1;
          w_pend_n  = 1'b0;
          w_ovr_n   = r_pend & w_rise;
        end else begin
          w_state_n = ST_IDLE;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
    w_busy_n = (w_state_n != ST_IDLE);
  end

  assign level_o   = r_level;
  assign pulse_o   = r_pulse;
  assign en_o      = r_en;
  assign busy_o    = r_busy;
  assign overrun_o = r_ovr;

endmodule

// File: tb/tb_pulse_conditioner.sv
// tb_pulse_conditioner: scoreboard bench for pulse_conditioner.
// Stimulus pushes expected event cycles; a negedge monitor pops and compares.
module tb_pulse_conditioner;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn = 1'b0;
  logic [19:0] db  = 20'd4;
  logic        level;
  logic        pulse;
  logic        en;
  logic        busy;
  logic        ovr;

  pulse_conditioner #(
    .DB_W    (20),
    .STRETCH (3)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .btn_i       (btn),
    .db_cycles_i (db),
    .level_o     (level),
    .pulse_o     (pulse),
    .en_o        (en),
    .busy_o      (busy),
    .overrun_o   (ovr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  int q_lvl[$];
  int q_pulse[$];
  int q_en[$];
  int q_enw[$];
  int q_bw[$];
  int q_ovr[$];

  logic lvl_p = 1'b0;
  logic en_p = 1'b0;
  logic busy_p = 1'b0;
  int   en_run = 0;
  int   busy_run = 0;

  task automatic cmp(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic exp_press(input int e0, input int thr);
    q_lvl.push_back(e0 + thr + 1);
    q_pulse.push_back(e0 + thr + 2);
  endtask

  task automatic exp_win(input int r, input int w);
    q_en.push_back(r);
    q_enw.push_back(w);
  endtask

  task automatic leftover(input string nm);
    cmp(nm, q_lvl.size() + q_pulse.size() + q_en.size()
          + q_enw.size() + q_bw.size() + q_ovr.size(), 0);
  endtask

  always @(negedge clk) begin
    if (level && !lvl_p) begin
      if (q_lvl.size() == 0) cmp("level_unexp", cyc, -1);
      else cmp("level_rise", cyc, q_lvl.pop_front());
    end
    if (pulse) begin
      if (q_pulse.size() == 0) cmp("pulse_unexp", cyc, -1);
      else cmp("pulse_cyc", cyc, q_pulse.pop_front());
    end
    if (ovr) begin
      if (q_ovr.size() == 0) cmp("ovr_unexp", cyc, -1);
      else cmp("ovr_cyc", cyc, q_ovr.pop_front());
    end
    if (en && !en_p) begin
      if (q_en.size() == 0) cmp("en_unexp", cyc, -1);
      else cmp("en_rise", cyc, q_en.pop_front());
    end
    if (en) begin
      en_run++;
    end else if (en_p) begin
      if (q_enw.size() == 0) cmp("enw_unexp", en_run, -1);
      else cmp("en_width", en_run, q_enw.pop_front());
      en_run = 0;
    end
    if (busy) begin
      busy_run++;
    end else if (busy_p) begin
      if (q_bw.size() == 0) cmp("busy_unexp", busy_run, -1);
      else cmp("busy_width", busy_run, q_bw.pop_front());
      busy_run = 0;
    end
    lvl_p  = level;
    en_p   = en;
    busy_p = busy;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    #1 rst = 1'b1;
    nclk(2);
    cmp("rst_level", int'(level), 0);
    cmp("rst_pulse", int'(pulse), 0);
    cmp("rst_en", int'(en), 0);
    cmp("rst_busy", int'(busy), 0);
    cmp("rst_ovr", int'(ovr), 0);
    rst = 1'b0;
    nclk(3);

    // 1 clean press, thr=4
    db = 20'd4;
    c = cyc;
    btn = 1'b1;
    exp_press(c + 1, 4);
    exp_win(c + 7, 3);
    q_bw.push_back(4);
    nclk(20);
    btn = 1'b0;
    nclk(15);
    leftover("t1_left");

    // 2 bounce, last toggle sampled at edge c+7
    c = cyc;
    btn = 1'b1;
    nclk(2);
    btn = 1'b0;
    nclk(1);
    btn = 1'b1;
    nclk(2);
    btn = 1'b0;
    nclk(1);
    btn = 1'b1;
    exp_press(c + 7, 4);
    exp_win(c + 13, 3);
    q_bw.push_back(4);
    nclk(20);
    btn = 1'b0;
    nclk(15);
    leftover("t2_left");

    // 3 back-to-back, thr=1
    db = 20'd1;
    c = cyc;
    btn = 1'b1;
    exp_press(c + 1, 1);
    exp_press(c + 3, 1);
    exp_win(c + 4, 3);
    exp_win(c + 8, 3);
    q_bw.push_back(8);
    nclk(1);
    btn = 1'b0;
    nclk(1);
    btn = 1'b1;
    nclk(20);
    btn = 1'b0;
    nclk(15);
    leftover("t3_left");

    // 4 overrun: third rise lands in GAP with a press pending
    c = cyc;
    btn = 1'b1;
    exp_press(c + 1, 1);
    exp_press(c + 3, 1);
    exp_press(c + 5, 1);
    exp_win(c + 4, 3);
    exp_win(c + 8, 3);
    q_bw.push_back(8);
    q_ovr.push_back(c + 8);
    nclk(1);
    btn = 1'b0;
    nclk(1);
    btn = 1'b1;
    nclk(1);
    btn = 1'b0;
    nclk(1);
    btn = 1'b1;
    nclk(20);
    btn = 1'b0;
    nclk(15);
    leftover("t4_left");

    // 5 reset in HIGH with pending set (just after edge c+6)
    c = cyc;
    btn = 1'b1;
    q_lvl.push_back(c + 3);
    q_lvl.push_back(c + 5);
    q_pulse.push_back(c + 4);
    exp_win(c + 4, 2);
    q_bw.push_back(2);
    nclk(1);
    btn = 1'b0;
    nclk(1);
    btn = 1'b1;
    nclk(3);
    @(posedge clk);
    #2;
    rst = 1'b1;
    btn = 1'b0;
    #1;
    cmp("mid_rst_level", int'(level), 0);
    cmp("mid_rst_pulse", int'(pulse), 0);
    cmp("mid_rst_en", int'(en), 0);
    cmp("mid_rst_busy", int'(busy), 0);
    cmp("mid_rst_ovr", int'(ovr), 0);
    nclk(3);
    rst = 1'b0;
    nclk(20);
    cmp("post_rst_en", int'(en), 0);
    leftover("t5_left");

    // 6 threshold 0 behaves as 1
    db = 20'd0;
    c = cyc;
    btn = 1'b1;
    exp_press(c + 1, 1);
    exp_win(c + 4, 3);
    q_bw.push_back(4);
    nclk(10);
    btn = 1'b0;
    nclk(15);
    leftover("t6_left");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
